vfp_stream_sink: RTL and testbench
==================================

VFP_STREAM_SINK -- requirements
Module: vfp_stream_sink

Interface
REQ-001 Parameter IMG_WIDTH, default 1920, active pixels per line (range 2..4095).
REQ-002 Parameter IMG_HEIGHT, default 1080, lines per frame (range 1..4095).
REQ-003 Port ACLK  input  1  single clock; all logic rising-edge.
REQ-004 Port ARESETN  input  1  reset; asynchronous assertion, active-low.
REQ-005 Port rgb_s_axis_tvalid  input  1  beat valid.
REQ-006 Port rgb_s_axis_tready  output  1  sink ready.
REQ-007 Port rgb_s_axis_tuser  input  1  start of frame, set on first pixel only.
REQ-008 Port rgb_s_axis_tlast  input  1  end of line, set on last pixel of each line.
REQ-009 Port rgb_s_axis_tdata  input  24  pixel {R[23:16],G[15:8],B[7:0]}.
REQ-010 Port stall_pattern  input  8  backpressure mask; 8'hFF means always ready.
REQ-011 Port frame_done  output  1  one-cycle pulse at frame end or abort.
REQ-012 Port frame_ok  output  1  status of the last frame; valid from frame_done onward.
REQ-013 Port err_flags  output  4  sticky: [0] missing/mid-frame SOF, [1] early EOL, [2] late EOL, [3] beat dropped in WAIT_SOF.
REQ-014 Port err_clear  input  1  synchronous clear of err_flags.
REQ-015 Port frame_count  output  16  frames completed with frame_ok=1; wraps 16'hFFFF->0.
REQ-016 Port frame_chksum  output  32  checksum of the last completed frame.

Function
REQ-017 A beat transfers only when tvalid=1 and tready=1 in the same cycle; all counters and state advance on transfers only.
REQ-018 tready = stall_pattern[ptr], where ptr is a 3-bit free-running counter incrementing every cycle; tready is registered and does not depend on tvalid.
REQ-019 FSM states: WAIT_SOF and ACTIVE; reset state WAIT_SOF.
REQ-020 WAIT_SOF: a transfer with tuser=0 is discarded and sets err_flags[3]; a transfer with tuser=1 enters ACTIVE, sets col=1, row=0, and loads chk = {8'h00,tdata}.
REQ-021 ACTIVE: each transfer updates chk_next = {chk[30:0],chk[31]} ^ {8'h00,tdata}; col increments.
REQ-022 Line end occurs on a transfer with tlast=1, or on the transfer at col==IMG_WIDTH-1; it resets col=0 and increments row.
REQ-023 tlast=1 with col<IMG_WIDTH-1 sets err_flags[1] and marks the frame bad.
REQ-024 col==IMG_WIDTH-1 with tlast=0 sets err_flags[2], marks the frame bad, and forces a line end.
REQ-025 A line end with row==IMG_HEIGHT-1 completes the frame:
  - frame_done pulses the next cycle.
  - frame_ok is set to (frame not marked bad).
  - frame_chksum loads chk_next.
  - frame_count increments if OK.
  - FSM returns to WAIT_SOF.
REQ-026 tuser=1 during ACTIVE on a beat that is not the first beat of a frame:
  - sets err_flags[0];
  - aborts the current frame (frame_done pulse, frame_ok=0, frame_chksum unchanged, frame_count unchanged);
  - treats the beat as a new SOF per REQ-020, staying in ACTIVE.
REQ-027 Frame completion and abort in the same beat cannot both occur; abort (REQ-026) takes priority.
REQ-028 err_clear takes priority over a same-cycle error set; set bits are visible the cycle after the causing transfer.
REQ-029 Latency: frame_done, frame_ok, frame_chksum and frame_count update exactly 1 cycle after the final transfer.

Reset
REQ-030 While ARESETN=0, all state takes its reset value:
  - tready=0, ptr=0, FSM=WAIT_SOF, col=0, row=0, chk=0;
  - frame_done=0, frame_ok=0, err_flags=0, frame_count=0, frame_chksum=0.
REQ-031 Reset asserted mid-frame discards the partial frame; the first cycle after deassertion drives tready=stall_pattern[0].

Verification
REQ-032 IMG_WIDTH=4, IMG_HEIGHT=2, stall_pattern=FF, 8 beats tdata=1..8 with correct tuser/tlast -> one frame_done, frame_ok=1, frame_count=1, err_flags=0, frame_chksum equal to the REQ-021 model result.
REQ-033 Same frame, tlast on beat 3 of line 0 -> err_flags[1]=1, frame_ok=0, frame_count unchanged.
REQ-034 Same frame, no tlast on line 1 -> err_flags[2]=1, frame completes on beat 8 with frame_ok=0.
REQ-035 tuser=1 on beat 5 -> frame_done with frame_ok=0 and err_flags[0]=1; the following 8 beats complete a good frame.
REQ-036 stall_pattern=8'hA5 with tvalid held high -> tready follows 1,0,1,0,0,1,0,1 repeating; beat-count results are identical to REQ-032.
REQ-037 Two beats with tuser=0 before SOF, then ARESETN pulsed mid-frame -> err_flags[3] set before reset; after reset all outputs are 0 and the next good frame gives frame_count=1.

Source files
------------

// File: rtl/vfp_stream_sink.sv
// Video frame sink for a 24-bit RGB AXI4-Stream: checks SOF/EOL framing against
// the configured geometry, accumulates a rotating checksum and reports per-frame status.
module vfp_stream_sink #(
  parameter int IMG_WIDTH  = 1920,
  parameter int IMG_HEIGHT = 1080
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        rgb_s_axis_tvalid,
  output logic        rgb_s_axis_tready,
  input  logic        rgb_s_axis_tuser,
  input  logic        rgb_s_axis_tlast,
  input  logic [23:0] rgb_s_axis_tdata,
  input  logic [7:0]  stall_pattern,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [3:0]  err_flags,
  input  logic        err_clear,
  output logic [15:0] frame_count,
  output logic [31:0] frame_chksum
);

  localparam logic [11:0] LAST_COL = 12'(IMG_WIDTH - 1);
  localparam logic [11:0] LAST_ROW = 12'(IMG_HEIGHT - 1);

  typedef enum logic {WAIT_SOF, ACTIVE} state_t;

  state_t      state, state_nxt;
  logic [11:0] col, col_nxt;
  logic [11:0] row, row_nxt;
  logic [31:0] chk, chk_nxt, chk_rot;
  logic        bad, bad_nxt;
  logic [2:0]  ptr;
  logic        xfer;
  logic        line_end;
  logic [3:0]  err_set;
  logic        done_nxt;
  logic        ok_nxt;
  logic        sum_load;
  logic        count_inc;

  // Backpressure is a pure function of time, independent of tvalid.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ptr               <= 3'd0;
      rgb_s_axis_tready <= 1'b0;
    end else begin
      ptr               <= ptr + 3'd1;
      rgb_s_axis_tready <= stall_pattern[ptr];
    end
  end

  assign xfer     = rgb_s_axis_tvalid & rgb_s_axis_tready;
  assign chk_rot  = {chk[30:0], chk[31]} ^ {8'h00, rgb_s_axis_tdata};
  assign line_end = rgb_s_axis_tlast | (col == LAST_COL);

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    chk_nxt   = chk;
    bad_nxt   = bad;
    err_set   = 4'b0000;
    done_nxt  = 1'b0;
    ok_nxt    = frame_ok;
    sum_load  = 1'b0;
    count_inc = 1'b0;

    if (xfer) begin
      unique case (state)
        WAIT_SOF: begin
          if (rgb_s_axis_tuser) begin
            state_nxt = ACTIVE;
            col_nxt   = 12'd1;
            row_nxt   = 12'd0;
            chk_nxt   = {8'h00, rgb_s_axis_tdata};
            bad_nxt   = 1'b0;
          end else begin
            err_set[3] = 1'b1;
          end
        end
        ACTIVE: begin
          if (rgb_s_axis_tuser) begin
            // A stray SOF aborts the frame and restarts on this very beat.
            err_set[0] = 1'b1;
            done_nxt   = 1'b1;
            ok_nxt     = 1'b0;
            col_nxt    = 12'd1;
            row_nxt    = 12'd0;
            chk_nxt    = {8'h00, rgb_s_axis_tdata};
            bad_nxt    = 1'b0;
          end else begin
            chk_nxt = chk_rot;
            if (rgb_s_axis_tlast && (col != LAST_COL)) begin
              err_set[1] = 1'b1;
              bad_nxt    = 1'b1;
            end
            if (!rgb_s_axis_tlast && (col == LAST_COL)) begin
              err_set[2] = 1'b1;
              bad_nxt    = 1'b1;
            end
            if (line_end) begin
              col_nxt = 12'd0;
              if (row == LAST_ROW) begin
                done_nxt  = 1'b1;
                ok_nxt    = !bad_nxt;
                sum_load  = 1'b1;
                count_inc = !bad_nxt;
                row_nxt   = 12'd0;
                state_nxt = WAIT_SOF;
              end else begin
                row_nxt = row + 12'd1;
              end
            end else begin
              col_nxt = col + 12'd1;
            end
          end
        end
        default: state_nxt = WAIT_SOF;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state        <= WAIT_SOF;
      col          <= 12'd0;
      row          <= 12'd0;
      chk          <= 32'd0;
      bad          <= 1'b0;
      frame_done   <= 1'b0;
      frame_ok     <= 1'b0;
      frame_count  <= 16'd0;
      frame_chksum <= 32'd0;
      err_flags    <= 4'b0000;
    end else begin
      state      <= state_nxt;
      col        <= col_nxt;
      row        <= row_nxt;
      chk        <= chk_nxt;
      bad        <= bad_nxt;
      frame_done <= done_nxt;
      frame_ok   <= ok_nxt;
      if (sum_load) frame_chksum <= chk_nxt;
      if (count_inc) frame_count <= frame_count + 16'd1;
      // Clear wins over a coincident error so software never loses a clear.
      if (err_clear) err_flags <= 4'b0000;
      else           err_flags <= err_flags | err_set;
    end
  end

endmodule

// File: tb/tb_vfp_stream_sink.sv
// Directed bench for vfp_stream_sink on a 4x2 image: a beat/line-counting model
// is compared every cycle, and hand-computed literals pin each scenario's outcome.
module tb_vfp_stream_sink;

  localparam int W = 4;
  localparam int H = 2;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        rgb_s_axis_tvalid;
  logic        rgb_s_axis_tready;
  logic        rgb_s_axis_tuser;
  logic        rgb_s_axis_tlast;
  logic [23:0] rgb_s_axis_tdata;
  logic [7:0]  stall_pattern;
  logic        frame_done;
  logic        frame_ok;
  logic [3:0]  err_flags;
  logic        err_clear;
  logic [15:0] frame_count;
  logic [31:0] frame_chksum;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int done_seen = 0;

  vfp_stream_sink #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .ACLK              (ACLK),
    .ARESETN           (ARESETN),
    .rgb_s_axis_tvalid (rgb_s_axis_tvalid),
    .rgb_s_axis_tready (rgb_s_axis_tready),
    .rgb_s_axis_tuser  (rgb_s_axis_tuser),
    .rgb_s_axis_tlast  (rgb_s_axis_tlast),
    .rgb_s_axis_tdata  (rgb_s_axis_tdata),
    .stall_pattern     (stall_pattern),
    .frame_done        (frame_done),
    .frame_ok          (frame_ok),
    .err_flags         (err_flags),
    .err_clear         (err_clear),
    .frame_count       (frame_count),
    .frame_chksum      (frame_chksum)
  );

  always #5 ACLK = ~ACLK;

  // Reference model: counts beats within the line and finished lines in the frame.
  logic        m_tready, n_tready;
  logic [2:0]  m_cyc, n_cyc;
  logic        m_in_frame, n_in_frame;
  int          m_beats, n_beats;
  int          m_lines, n_lines;
  logic        m_bad, n_bad;
  logic [31:0] m_chk, n_chk;
  logic        m_done, n_done;
  logic        m_ok, n_ok;
  logic [3:0]  m_err, n_err;
  logic [15:0] m_cnt, n_cnt;
  logic [31:0] m_sum, n_sum;
  logic [3:0]  new_err;
  logic [31:0] rot;
  int          beats;
  logic        bad_l;

  always_comb begin
    n_tready   = stall_pattern[m_cyc];
    n_cyc      = m_cyc + 3'd1;
    n_in_frame = m_in_frame;
    n_beats    = m_beats;
    n_lines    = m_lines;
    n_bad      = m_bad;
    n_chk      = m_chk;
    n_done     = 1'b0;
    n_ok       = m_ok;
    n_cnt      = m_cnt;
    n_sum      = m_sum;
    new_err    = 4'b0000;
    rot        = 32'd0;
    beats      = 0;
    bad_l      = 1'b0;
    if (rgb_s_axis_tvalid && m_tready) begin
      if (rgb_s_axis_tuser) begin
        if (m_in_frame) begin
          new_err[0] = 1'b1;
          n_done     = 1'b1;
          n_ok       = 1'b0;
        end
        n_in_frame = 1'b1;
        n_beats    = 1;
        n_lines    = 0;
        n_bad      = 1'b0;
        n_chk      = {8'h00, rgb_s_axis_tdata};
      end else if (!m_in_frame) begin
        new_err[3] = 1'b1;
      end else begin
        rot   = {m_chk[30:0], m_chk[31]} ^ {8'h00, rgb_s_axis_tdata};
        n_chk = rot;
        beats = m_beats + 1;
        bad_l = m_bad;
        if (rgb_s_axis_tlast && beats < W) begin new_err[1] = 1'b1; bad_l = 1'b1; end
        if (!rgb_s_axis_tlast && beats == W) begin new_err[2] = 1'b1; bad_l = 1'b1; end
        n_bad = bad_l;
        if (rgb_s_axis_tlast || beats == W) begin
          n_beats = 0;
          if (m_lines + 1 == H) begin
            n_done     = 1'b1;
            n_ok       = !bad_l;
            n_sum      = rot;
            n_in_frame = 1'b0;
            n_lines    = 0;
            if (!bad_l) n_cnt = m_cnt + 16'd1;
          end else begin
            n_lines = m_lines + 1;
          end
        end else begin
          n_beats = beats;
        end
      end
    end
    n_err = err_clear ? 4'b0000 : (m_err | new_err);
  end

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      m_tready <= 1'b0; m_cyc <= 3'd0; m_in_frame <= 1'b0; m_beats <= 0; m_lines <= 0;
      m_bad <= 1'b0; m_chk <= 32'd0; m_done <= 1'b0; m_ok <= 1'b0; m_err <= 4'b0000;
      m_cnt <= 16'd0; m_sum <= 32'd0;
    end else begin
      m_tready <= n_tready; m_cyc <= n_cyc; m_in_frame <= n_in_frame; m_beats <= n_beats;
      m_lines <= n_lines; m_bad <= n_bad; m_chk <= n_chk; m_done <= n_done; m_ok <= n_ok;
      m_err <= n_err; m_cnt <= n_cnt; m_sum <= n_sum;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  initial begin
    @(posedge ACLK);
    forever begin
      @(negedge ACLK);
      if (frame_done === 1'b1) done_seen++;
      checkOutput("tready", 32'(rgb_s_axis_tready), 32'(m_tready));
      checkOutput("frame_done", 32'(frame_done), 32'(m_done));
      checkOutput("frame_ok", 32'(frame_ok), 32'(m_ok));
      checkOutput("err_flags", 32'(err_flags), 32'(m_err));
      checkOutput("frame_count", 32'(frame_count), 32'(m_cnt));
      checkOutput("frame_chksum", frame_chksum, m_sum);
    end
  end

  task automatic settle();
    @(negedge ACLK);
    #1;
  endtask

  task automatic send_beat(input logic [23:0] d, input logic u, input logic l);
    int waited;
    @(negedge ACLK);
    rgb_s_axis_tvalid = 1'b1;
    rgb_s_axis_tdata  = d;
    rgb_s_axis_tuser  = u;
    rgb_s_axis_tlast  = l;
    waited = 0;
    while (rgb_s_axis_tready !== 1'b1 && waited < 32) begin
      @(negedge ACLK);
      waited++;
    end
    if (waited >= 32) begin
      total_cnt++;
      bad_cnt++;
      $display("[TB] FAIL tready_timeout: got no tready within 32 cycles expected handshake");
    end else begin
      @(posedge ACLK);
    end
  endtask

  // Sends n beats with data first_d, first_d+1, ...; masks give tuser/tlast per beat.
  task automatic applyStimulus(input int n, input logic [7:0] user_m, input logic [7:0] last_m,
                               input int first_d);
    for (int i = 0; i < n; i++)
      send_beat(24'(first_d + i), user_m[i], last_m[i]);
    @(negedge ACLK);
    rgb_s_axis_tvalid = 1'b0;
    rgb_s_axis_tuser  = 1'b0;
    rgb_s_axis_tlast  = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge ACLK);
    err_clear = 1'b1;
    @(negedge ACLK);
    err_clear = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_done"}, 32'(frame_done), 32'd0);
    checkOutput({tag, "_ok"}, 32'(frame_ok), 32'd0);
    checkOutput({tag, "_err"}, 32'(err_flags), 32'd0);
    checkOutput({tag, "_count"}, 32'(frame_count), 32'd0);
    checkOutput({tag, "_chksum"}, frame_chksum, 32'd0);
  endtask

  task automatic check_frame(input string tag, input logic ok, input logic [3:0] err,
                             input logic [15:0] cnt, input logic [31:0] sum);
    checkOutput({tag, "_ok"}, 32'(frame_ok), 32'(ok));
    checkOutput({tag, "_err"}, 32'(err_flags), 32'(err));
    checkOutput({tag, "_count"}, 32'(frame_count), 32'(cnt));
    checkOutput({tag, "_chksum"}, frame_chksum, sum);
  endtask

  task automatic do_reset();
    @(posedge ACLK);
    #2;
    ARESETN = 1'b0;
    rgb_s_axis_tvalid = 1'b0;
    rgb_s_axis_tuser  = 1'b0;
    rgb_s_axis_tlast  = 1'b0;
    repeat (2) @(posedge ACLK);
    settle();
    checkOutput("rst_tready", 32'(rgb_s_axis_tready), 32'd0);
    check_all_zero("rst");
    @(posedge ACLK);
    #2;
    ARESETN = 1'b1;
  endtask

  initial begin
    int d0;
    logic [7:0] pat;
    ARESETN           = 1'b0;
    rgb_s_axis_tvalid = 1'b0;
    rgb_s_axis_tuser  = 1'b0;
    rgb_s_axis_tlast  = 1'b0;
    rgb_s_axis_tdata  = 24'd0;
    stall_pattern     = 8'hFF;
    err_clear         = 1'b0;
    do_reset();

    // Good 4x2 frame of data 1..8: checksum 0x16.
    $display("[TB] good frame");
    d0 = done_seen;
    applyStimulus(8, 8'h01, 8'h88, 1);
    settle();
    check_frame("good", 1'b1, 4'b0000, 16'd1, 32'h16);
    checkOutput("good_pulses", 32'(done_seen - d0), 32'd1);

    // Early EOL on beat 3; the 7-beat frame ends bad with checksum 0x0F.
    $display("[TB] early eol");
    pulse_clear();
    applyStimulus(7, 8'h01, 8'h44, 1);
    settle();
    check_frame("early", 1'b0, 4'b0010, 16'd1, 32'h0F);

    // No tlast on line 1: forced line end at beat 8, frame bad.
    $display("[TB] late eol");
    pulse_clear();
    d0 = done_seen;
    applyStimulus(8, 8'h01, 8'h08, 1);
    settle();
    check_frame("late", 1'b0, 4'b0100, 16'd1, 32'h16);
    checkOutput("late_pulses", 32'(done_seen - d0), 32'd1);

    // SOF on beat 5 aborts, then that beat starts a good frame.
    $display("[TB] abort");
    pulse_clear();
    d0 = done_seen;
    applyStimulus(4, 8'h01, 8'h08, 1);
    applyStimulus(8, 8'h01, 8'h88, 1);
    settle();
    check_frame("abort", 1'b1, 4'b0001, 16'd2, 32'h16);
    checkOutput("abort_pulses", 32'(done_seen - d0), 32'd2);

    // Backpressure pattern A5 after a fresh reset.
    $display("[TB] stall pattern");
    stall_pattern = 8'hA5;
    do_reset();
    @(posedge ACLK);
    for (int i = 0; i < 8; i++) begin
      @(negedge ACLK);
      pat[i] = rgb_s_axis_tready;
    end
    checkOutput("stall_seq", 32'(pat), 32'hA5);
    applyStimulus(8, 8'h01, 8'h88, 1);
    settle();
    check_frame("stall", 1'b1, 4'b0000, 16'd1, 32'h16);

    // Dropped beats before SOF, then reset mid-frame.
    $display("[TB] drop and reset");
    stall_pattern = 8'hFF;
    pulse_clear();
    applyStimulus(2, 8'h00, 8'h00, 40);
    settle();
    checkOutput("drop_err", 32'(err_flags), 32'h8);
    applyStimulus(3, 8'h01, 8'h00, 1);
    do_reset();
    settle();
    check_all_zero("post_rst");
    applyStimulus(8, 8'h01, 8'h88, 1);
    settle();
    check_frame("after_rst", 1'b1, 4'b0000, 16'd1, 32'h16);

    repeat (4) @(negedge ACLK);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
